// File: rtl/if_pc_redirect.sv
// IF-stage PC unit and IF/ID pipeline register. Branch/jump decisions made in
// ID redirect fetch with no delay slot; the instruction fetched behind them is squashed.
module if_pc_redirect #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  input  logic        i_stall,
  input  logic        i_con_ifbranch,
  input  logic        i_con_jump,
  input  logic        i_con_jr,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_jaddr26,
  input  logic [31:0] i_data_rs,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_instr_id,
  output logic [31:0] o_pc4_id,
  output logic        o_id_valid,
  output logic        o_redirect,
  output logic [15:0] o_redirect_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic [XLEN-1:0]  pc_q,    pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  pc4id_q, pc4id_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             req;
  logic             redirect_c;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  br_offset;

  // Redirect target selection: jr beats jump beats branch.
  always_comb begin
    br_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    pc_plus4  = pc_q + XLEN'(4);
    req       = valid_q & (i_con_ifbranch | i_con_jump | i_con_jr);
    if (i_con_jr) begin
      target = i_data_rs;
    end else if (i_con_jump) begin
      target = {pc4id_q[31:28], i_jaddr26, 2'b00};
    end else begin
      target = pc4id_q + br_offset;
    end
  end

  // Next-state: stall > redirect > fetch bubble > normal advance.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4id_d    = pc4id_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    redirect_c = 1'b0;
    if (!i_stall) begin
      if (req) begin
        pc_d       = target;
        instr_d    = NOP_INSTR;
        valid_d    = 1'b0;
        redirect_c = ~i_rst;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (!i_imem_ready) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        instr_d = i_imem_rdata;
        pc4id_d = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4id_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4id_q <= pc4id_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_imem_addr    = pc_q;
  assign o_instr_id     = instr_q;
  assign o_pc4_id       = pc4id_q;
  assign o_id_valid     = valid_q;
  assign o_redirect     = redirect_c;
  assign o_redirect_cnt = cnt_q;

endmodule
